// File: rtl/uart_tx_fifo.sv
// Transmit FIFO in front of uart_tx: the CPU pushes bytes over the peripheral bus and an
// FSM drains them one at a time through uart_tx's byte/go/done handshake.
module uart_tx_fifo #(
  parameter int BITS  = 16,
  parameter int DEPTH = 16
) (
  input  logic            CLK,
  input  logic            RSTb,
  input  logic [7:0]      ADDRESS,
  input  logic [BITS-1:0] DATA_IN,
  output logic [BITS-1:0] DATA_OUT,
  input  logic            WRb,
  output logic [7:0]      TX_BYTE,
  output logic            TX_GO,
  input  logic            TX_DONE
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [7:0] ADDR_DATA   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_CLR    = 8'h02;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          ovf;

  logic full;
  logic empty;
  logic idle;
  logic push_req;
  logic push;
  logic pop;
  logic ovf_clr;
  logic unused_data_hi;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign idle     = empty && (state == S_IDLE) && TX_DONE;
  assign push_req = !WRb && (ADDRESS == ADDR_DATA);
  assign push     = push_req && !full;
  assign pop      = (state == S_IDLE) && !empty;
  assign ovf_clr  = !WRb && (ADDRESS == ADDR_CLR);

  // Only the low byte of a data write is ever stored.
  assign unused_data_hi = ^DATA_IN[BITS-1:8];

  // NOTE: the storage array has no reset; pointers and count define which entries are valid,
  // so clearing the data itself would only cost a reset net to every flop.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= DATA_IN[7:0];
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full) ovf <= 1'b1;
      else if (ovf_clr)     ovf <= 1'b0;
    end
  end

  // TX_GO is high only for the cycle spent in S_SEND; TX_BYTE holds until the next pop.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state   <= S_IDLE;
      TX_BYTE <= 8'h00;
      TX_GO   <= 1'b0;
    end else begin
      TX_GO <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            TX_BYTE <= mem[rd_ptr];
            TX_GO   <= 1'b1;
            state   <= S_SEND;
          end
        end
        S_SEND:      state <= S_WAIT_BUSY;
        S_WAIT_BUSY: if (!TX_DONE) state <= S_WAIT_DONE;
        S_WAIT_DONE: if (TX_DONE)  state <= S_IDLE;
        default:     state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    DATA_OUT = '0;
    case (ADDRESS)
      ADDR_STATUS: begin
        DATA_OUT[8+AW:8] = count;
        DATA_OUT[2]      = ovf;
        DATA_OUT[1]      = full;
        DATA_OUT[0]      = idle;
      end
      default: DATA_OUT = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a behavioural uart_tx model and serial decoder feed two scoreboards
// (TX_GO byte and decoded serial byte), and each scenario task checks status inline.
module tb_uart_tx_fifo;

  localparam int BIT_CLKS = 4;

  logic        CLK;
  logic        RSTb;
  logic [7:0]  ADDRESS;
  logic [15:0] DATA_IN;
  logic [15:0] DATA_OUT;
  logic        WRb;
  logic [7:0]  TX_BYTE;
  logic        TX_GO;
  logic        TX_DONE;

  logic        uart_done;
  logic        uart_busy;
  logic        serial;
  logic        stall;
  logic        rx_en;

  logic [7:0]  exp_go[$];
  logic [7:0]  exp_ser[$];
  int          go_count;
  int          checks;
  int          fails;

  assign TX_DONE = uart_done && !stall;

  uart_tx_fifo #(.BITS(16), .DEPTH(16)) dut (
    .CLK      (CLK),
    .RSTb     (RSTb),
    .ADDRESS  (ADDRESS),
    .DATA_IN  (DATA_IN),
    .DATA_OUT (DATA_OUT),
    .WRb      (WRb),
    .TX_BYTE  (TX_BYTE),
    .TX_GO    (TX_GO),
    .TX_DONE  (TX_DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // uart_tx model: 10-bit frame, BIT_CLKS clocks per bit, shares RSTb.
  initial begin
    logic [9:0] frame;
    int         cnt;
    uart_done = 1'b1;
    uart_busy = 1'b0;
    serial    = 1'b1;
    frame     = '1;
    cnt       = 0;
    forever begin
      @(negedge CLK);
      if (!RSTb) begin
        uart_busy = 1'b0;
        uart_done = 1'b1;
        serial    = 1'b1;
      end else if (!uart_busy) begin
        if (TX_GO === 1'b1) begin
          frame     = {1'b1, TX_BYTE, 1'b0};
          cnt       = 0;
          uart_busy = 1'b1;
          uart_done = 1'b0;
          serial    = frame[0];
        end
      end else begin
        cnt++;
        if (cnt == 10 * BIT_CLKS) begin
          uart_busy = 1'b0;
          uart_done = 1'b1;
          serial    = 1'b1;
        end else begin
          serial = frame[cnt / BIT_CLKS];
        end
      end
    end
  end

  // TX_GO monitor: every pulse must carry the next expected byte.
  initial begin
    logic [7:0] exp;
    go_count = 0;
    forever begin
      @(negedge CLK);
      if (TX_GO === 1'b1) begin
        go_count++;
        checks++;
        if (exp_go.size() == 0) begin
          fails++;
          $display("FAIL tx_go_unexpected: TX_BYTE=%02h, expected no pulse", TX_BYTE);
        end else begin
          exp = exp_go.pop_front();
          if (TX_BYTE !== exp) begin
            fails++;
            $display("FAIL tx_byte: got %02h, expected %02h", TX_BYTE, exp);
          end
        end
      end
    end
  end

  // Serial decoder, sampling mid-bit on posedges (the model changes the line on negedges).
  initial begin
    logic [7:0] rx;
    logic [7:0] exp;
    rx = '0;
    forever begin
      @(posedge CLK);
      if (serial === 1'b0) begin
        repeat (BIT_CLKS / 2) @(posedge CLK);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CLKS) @(posedge CLK);
          rx[i] = serial;
        end
        repeat (BIT_CLKS) @(posedge CLK);
        if (rx_en) begin
          checks++;
          if (exp_ser.size() == 0) begin
            fails++;
            $display("FAIL serial_unexpected: got %02h, expected no frame", rx);
          end else begin
            exp = exp_ser.pop_front();
            if (rx !== exp || serial !== 1'b1) begin
              fails++;
              $display("FAIL serial_byte: got %02h stop=%b, expected %02h stop=1", rx, serial, exp);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end on a negedge.
  task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
    ADDRESS = a;
    DATA_IN = d;
    WRb     = 1'b0;
    @(negedge CLK);
    WRb     = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_go.push_back(b);
    exp_ser.push_back(b);
    bus_write(8'h00, {8'h00, b});
  endtask

  task automatic read_status(output logic [15:0] s);
    ADDRESS = 8'h01;
    #1 s = DATA_OUT;
  endtask

  task automatic wait_go(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (TX_GO === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    logic [15:0] s;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      read_status(s);
      if (s[0] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [15:0] s;
    int          g0;
    read_status(s);
    checks++;
    if (s !== 16'h0001) begin
      fails++;
      $display("FAIL reset_status: got %04h, expected 0001", s);
    end
    checks++;
    if (TX_GO !== 1'b0 || TX_BYTE !== 8'h00) begin
      fails++;
      $display("FAIL reset_outputs: TX_GO=%b TX_BYTE=%02h, expected 0 and 00", TX_GO, TX_BYTE);
    end
    g0 = go_count;
    repeat (100) @(negedge CLK);
    checks++;
    if (go_count !== g0) begin
      fails++;
      $display("FAIL reset_quiet: %0d pulses, expected 0", go_count - g0);
    end
  endtask

  task automatic test_single;
    logic [15:0] s;
    bit          ok;
    push_byte(8'h41);
    checks++;
    if (TX_GO !== 1'b0) begin
      fails++;
      $display("FAIL single_go_early: TX_GO=%b, expected 0 right after the write edge", TX_GO);
    end
    @(negedge CLK);
    checks++;
    if (TX_GO !== 1'b1 || TX_BYTE !== 8'h41) begin
      fails++;
      $display("FAIL single_latency: TX_GO=%b TX_BYTE=%02h, expected 1 and 41", TX_GO, TX_BYTE);
    end
    @(negedge CLK);
    checks++;
    if (TX_GO !== 1'b0) begin
      fails++;
      $display("FAIL single_go_width: TX_GO=%b, expected 0 after one cycle", TX_GO);
    end
    wait_idle(200, ok);
    read_status(s);
    checks++;
    if (!ok || s !== 16'h0001 || exp_ser.size() != 0 || exp_go.size() != 0) begin
      fails++;
      $display("FAIL single_done: idle_seen=%b status=%04h pending_ser=%0d, expected 1 0001 0",
               ok, s, exp_ser.size());
    end
  endtask

  task automatic test_burst;
    logic [15:0] s;
    bit          ok;
    for (int i = 0; i < 16; i++) push_byte(8'(8'h30 + i));
    read_status(s);
    checks++;
    if (s[12:8] !== 5'd15) begin
      fails++;
      $display("FAIL burst_peak_count: got %0d, expected 15", s[12:8]);
    end
    for (int i = 1; i < 16; i++) begin
      wait_go(200, ok);
      read_status(s);
      checks++;
      if (!ok || s[12:8] !== 5'(15 - i)) begin
        fails++;
        $display("FAIL burst_count: pulse_seen=%b count=%0d, expected 1 and %0d", ok, s[12:8], 15 - i);
      end
    end
    wait_idle(300, ok);
    checks++;
    if (!ok || exp_go.size() != 0 || exp_ser.size() != 0) begin
      fails++;
      $display("FAIL burst_drain: idle_seen=%b pending_go=%0d pending_ser=%0d, expected 1 0 0",
               ok, exp_go.size(), exp_ser.size());
    end
  endtask

  task automatic test_overflow;
    logic [15:0] s;
    bit          ok;
    push_byte(8'h55);
    wait_go(10, ok);
    stall = 1'b1;
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL ovf_first_go: no TX_GO, expected one");
    end
    for (int i = 0; i < 17; i++) begin
      if (i < 16) push_byte(8'(8'h60 + i));
      else        bus_write(8'h00, 16'h00EE);
    end
    read_status(s);
    checks++;
    if (s !== 16'h1006) begin
      fails++;
      $display("FAIL ovf_full_status: got %04h, expected 1006", s);
    end
    bus_write(8'h02, 16'h0000);
    read_status(s);
    checks++;
    if (s !== 16'h1002) begin
      fails++;
      $display("FAIL ovf_clear: got %04h, expected 1002", s);
    end
    stall = 1'b0;
    wait_idle(2000, ok);
    read_status(s);
    checks++;
    if (!ok || s !== 16'h0001 || exp_go.size() != 0 || exp_ser.size() != 0) begin
      fails++;
      $display("FAIL ovf_drain: idle_seen=%b status=%04h pending_go=%0d, expected 1 0001 0",
               ok, s, exp_go.size());
    end
  endtask

  task automatic test_simultaneous;
    logic [15:0] s;
    bit          ok;
    push_byte(8'hA0);
    wait_go(10, ok);
    stall = 1'b1;
    for (int i = 1; i < 4; i++) push_byte(8'(8'hA0 + i));
    read_status(s);
    checks++;
    if (!ok || s !== 16'h0300) begin
      fails++;
      $display("FAIL simul_setup: go_seen=%b status=%04h, expected 1 and 0300", ok, s);
    end
    for (int i = 0; i < 100 && uart_busy; i++) @(negedge CLK);
    stall = 1'b0;
    @(negedge CLK);
    push_byte(8'hA4);
    read_status(s);
    checks++;
    if (TX_GO !== 1'b1 || s !== 16'h0300) begin
      fails++;
      $display("FAIL simul_push_pop: TX_GO=%b status=%04h, expected 1 and 0300", TX_GO, s);
    end
    wait_idle(1000, ok);
    checks++;
    if (!ok || exp_go.size() != 0 || exp_ser.size() != 0) begin
      fails++;
      $display("FAIL simul_drain: idle_seen=%b pending_go=%0d pending_ser=%0d, expected 1 0 0",
               ok, exp_go.size(), exp_ser.size());
    end
  endtask

  task automatic test_reset_mid_byte;
    logic [15:0] s;
    bit          ok;
    int          g0;
    rx_en = 1'b0;
    push_byte(8'hB0);
    wait_go(10, ok);
    for (int i = 1; i < 6; i++) bus_write(8'h00, 16'(16'h00B0 + i));
    read_status(s);
    checks++;
    if (!ok || s !== 16'h0500) begin
      fails++;
      $display("FAIL rst_setup: go_seen=%b status=%04h, expected 1 and 0500", ok, s);
    end
    RSTb = 1'b0;
    @(negedge CLK);
    read_status(s);
    checks++;
    if (TX_GO !== 1'b0 || TX_BYTE !== 8'h00 || s !== 16'h0001) begin
      fails++;
      $display("FAIL rst_mid_byte: TX_GO=%b TX_BYTE=%02h status=%04h, expected 0 00 0001",
               TX_GO, TX_BYTE, s);
    end
    RSTb = 1'b1;
    exp_go.delete();
    exp_ser.delete();
    g0 = go_count;
    repeat (100) @(negedge CLK);
    read_status(s);
    checks++;
    if (go_count !== g0 || s !== 16'h0001) begin
      fails++;
      $display("FAIL rst_quiet: pulses=%0d status=%04h, expected 0 and 0001", go_count - g0, s);
    end
  endtask

  initial begin
    checks  = 0;
    fails   = 0;
    RSTb    = 1'b0;
    WRb     = 1'b1;
    ADDRESS = 8'h00;
    DATA_IN = 16'h0000;
    stall   = 1'b0;
    rx_en   = 1'b1;
    repeat (3) @(negedge CLK);
    RSTb = 1'b1;
    @(negedge CLK);
    test_reset;
    test_single;
    test_burst;
    test_overflow;
    test_simultaneous;
    test_reset_mid_byte;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
